// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared types and constants for the count_ctrl run-control
// sequencer and its counter core.
//   COUNT_WIDTH : default counter/limit width in bits
//   STATE_WIDTH : width of the exported FSM state encoding
//   state_t     : FSM states (encoding 2'd3 is illegal)
package count_ctrl_pkg;

    localparam int unsigned COUNT_WIDTH = 4;
    localparam int unsigned STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // A run is in progress whenever the FSM is counting or frozen.
    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage : count_ctrl_pkg

// File: rtl/cnt_core.sv
// cnt_core: WIDTH-bit up-counter register with synchronous clear, enable and
// hold. Pure datapath; all sequencing decisions come from the caller.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset (count -> 0)
//   clr    : synchronous clear to 0 (wins over en)
//   en     : increment by one, modulo 2^WIDTH; otherwise hold
//   count  : registered count value
module cnt_core
    import count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Counter register: reset > clear > increment > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule : cnt_core

// File: rtl/count_ctrl.sv
// count_ctrl: run-control sequencer around a free-running up-counter.
// Adds start/stop/pause commands, a programmable terminal value, one-shot or
// periodic mode, and single-cycle terminal-count / done pulses.
// Optional build macro: COUNT_CTRL_IRQ_EN enables the sticky irq flag;
// without it irq is tied low and irq_clr is ignored (ports unchanged).
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   start    : pulse, begins a run (IDLE only, ignored while stop=1)
//   stop     : pulse, aborts the run, count cleared, back to IDLE
//   pause    : level, freezes the count while high
//   periodic : mode sampled at start (1 = auto-reload, 0 = one-shot)
//   limit    : terminal value sampled at start
//   irq_clr  : clears irq (set has priority)
//   count    : current count
//   busy     : high in RUN or PAUSE
//   tc       : one-cycle terminal-count pulse
//   done     : one-cycle pulse when a one-shot run completes
//   state    : FSM state encoding (IDLE=0, RUN=1, PAUSE=2)
//   irq      : sticky interrupt flag
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   periodic,
    input  logic [WIDTH-1:0]       limit,
    input  logic                   irq_clr,
    output logic [WIDTH-1:0]       count,
    output logic                   busy,
    output logic                   tc,
    output logic                   done,
    output logic [STATE_WIDTH-1:0] state,
    output logic                   irq
);

    state_t           state_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;

    logic             cnt_clr_c;
    logic             cnt_en_c;
    logic             tc_set_c;
    logic             done_set_c;
    logic             at_limit_c;

    assign at_limit_c = (count == limit_q);

    // Per-cycle event decode: counter control and pulse requests.
    // Priority inside RUN is stop > pause > terminal count > increment.
    always_comb begin
        cnt_clr_c  = 1'b0;
        cnt_en_c   = 1'b0;
        tc_set_c   = 1'b0;
        done_set_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    cnt_clr_c = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    cnt_clr_c = 1'b1;
                end else if (pause) begin
                    cnt_en_c = 1'b0;
                end else if (at_limit_c) begin
                    tc_set_c = 1'b1;
                    if (mode_q) begin
                        // Periodic reload; limit=0 yields a tc every cycle.
                        cnt_clr_c = 1'b1;
                    end else begin
                        // One-shot leaves the count parked at the limit.
                        done_set_c = 1'b1;
                    end
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    cnt_clr_c = 1'b1;
                end
            end
            default: begin
                cnt_clr_c = 1'b0;
            end
        endcase
    end

    // Run-control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            mode_q  <= 1'b0;
            busy    <= 1'b0;
            tc      <= 1'b0;
            done    <= 1'b0;
        end else begin
            tc   <= tc_set_c;
            done <= done_set_c;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        limit_q <= limit;
                        mode_q  <= periodic;
                        state_q <= ST_RUN;
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (pause) begin
                        state_q <= ST_PAUSE;
                    end else if (done_set_c) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (!pause) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    // Illegal encoding: recover to a quiet IDLE.
                    state_q <= ST_IDLE;
                    busy    <= is_busy(ST_IDLE);
                end
            endcase
        end
    end

    assign state = state_q;

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_cnt_core (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_c),
        .en    (cnt_en_c),
        .count (count)
    );

`ifdef COUNT_CTRL_IRQ_EN
    // Sticky interrupt: set on a tc/done event (as it is raised and while
    // it is visible), so a clear coinciding with a pulse never drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (tc_set_c || done_set_c || tc || done) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq_clr;

    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule : count_ctrl

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed, scoreboard-checked bench for count_ctrl.
// Stimulus drives inputs on the falling edge and queues the expected outputs
// for the following rising edge; an independent monitor pops and compares
// just after each rising edge.
module tb_count_ctrl;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         busy;
        logic         tc;
        logic         done;
        logic [1:0]   st;
        logic         irq;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic         stop;
    logic         pause;
    logic         periodic;
    logic [W-1:0] limit;
    logic         irq_clr;
    logic [W-1:0] count;
    logic         busy;
    logic         tc;
    logic         done;
    logic [1:0]   state;
    logic         irq;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference irq model state (expected previous-cycle pulses).
    logic  m_irq  = 1'b0;
    logic  m_tc   = 1'b0;
    logic  m_done = 1'b0;

    count_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .periodic (periodic),
        .limit    (limit),
        .irq_clr  (irq_clr),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done),
        .state    (state),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, queue what must appear after the next edge.
    task automatic cyc(input logic rs, input logic st, input logic sp,
                       input logic pa, input logic per, input logic [W-1:0] lim,
                       input logic ic, input logic [W-1:0] e_cnt,
                       input logic e_tc, input logic e_done,
                       input logic [1:0] e_st, input string nm);
        exp_t e;
        @(negedge clk);
        reset    = rs;
        start    = st;
        stop     = sp;
        pause    = pa;
        periodic = per;
        limit    = lim;
        irq_clr  = ic;
`ifdef COUNT_CTRL_IRQ_EN
        if (rs) m_irq = 1'b0;
        else if (e_tc || e_done || m_tc || m_done) m_irq = 1'b1;
        else if (ic) m_irq = 1'b0;
`else
        m_irq = 1'b0;
`endif
        m_tc   = e_tc;
        m_done = e_done;
        e.cnt  = e_cnt;
        e.busy = (e_st == 2'd1) || (e_st == 2'd2);
        e.tc   = e_tc;
        e.done = e_done;
        e.st   = e_st;
        e.irq  = m_irq;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare DUT outputs against the scoreboard after each edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (count !== e.cnt || busy !== e.busy || tc !== e.tc ||
                    done !== e.done || state !== e.st || irq !== e.irq) begin
                    errors++;
                    $display("FAIL %s @%0t: got cnt=%0d busy=%b tc=%b done=%b st=%0d irq=%b, want cnt=%0d busy=%b tc=%b done=%b st=%0d irq=%b",
                             nm, $time, count, busy, tc, done, state, irq,
                             e.cnt, e.busy, e.tc, e.done, e.st, e.irq);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        periodic = 1'b0; limit = '0; irq_clr = 1'b0;

        // Reset and idle no-ops
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        cyc(1, 1, 0, 0, 1, 7, 0, 0, 0, 0, 0, "reset_start");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "stop_idle");

        // Periodic, limit 3; mid-run mode/limit changes and start ignored
        cyc(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 1, "p3_start");
        for (int i = 1; i <= 10; i++)
            cyc(0, (i == 5), 0, 0, 0, 7, 0, W'(i % 4), (i % 4 == 0), 0, 1, "p3_run");
        cyc(0, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0, "p3_stop");

        // One-shot, limit 5
        cyc(0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 1, "os5_start");
        for (int i = 1; i <= 5; i++)
            cyc(0, 0, 0, 0, 1, 5, 0, W'(i), 0, 0, 1, "os5_run");
        cyc(0, 0, 0, 0, 0, 5, 0, 5, 1, 1, 0, "os5_done");
        cyc(0, 0, 0, 0, 0, 5, 0, 5, 0, 0, 0, "os5_hold");
        cyc(0, 0, 0, 0, 0, 5, 0, 5, 0, 0, 0, "os5_hold");

        // Periodic, limit 9, pause at count 4
        cyc(0, 1, 0, 0, 1, 9, 0, 0, 0, 0, 1, "p9_start");
        for (int i = 1; i <= 4; i++)
            cyc(0, 0, 0, 0, 1, 9, 0, W'(i), 0, 0, 1, "p9_run");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 1, 1, 9, 0, 4, 0, 0, 2, "p9_pause");
        cyc(0, 0, 0, 0, 1, 9, 0, 4, 0, 0, 1, "p9_resume");
        for (int i = 5; i <= 7; i++)
            cyc(0, 0, 0, 0, 1, 9, 0, W'(i), 0, 0, 1, "p9_cont");
        cyc(0, 0, 1, 0, 1, 9, 0, 0, 0, 0, 0, "p9_stop");

        // Stop + start together while paused at count 2
        cyc(0, 1, 0, 0, 1, 9, 0, 0, 0, 0, 1, "ps_start");
        cyc(0, 0, 0, 0, 1, 9, 0, 1, 0, 0, 1, "ps_run");
        cyc(0, 0, 0, 0, 1, 9, 0, 2, 0, 0, 1, "ps_run");
        cyc(0, 0, 0, 1, 1, 9, 0, 2, 0, 0, 2, "ps_pause");
        cyc(0, 1, 1, 1, 1, 9, 0, 0, 0, 0, 0, "ps_stop_start");
        cyc(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, "ps_start_ignored");
        cyc(0, 1, 1, 0, 1, 9, 0, 0, 0, 0, 0, "idle_start_with_stop");

        // limit 0: periodic tc every cycle, one-shot done after one cycle
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, "l0p_start");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, "l0p_tc");
        cyc(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, "l0p_stop");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "l0os_start");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "l0os_done");

        // limit 15 (all ones), periodic: wraps via reload, tc once per 16
        cyc(0, 1, 0, 0, 1, 15, 0, 0, 0, 0, 1, "l15_start");
        for (int i = 1; i <= 32; i++)
            cyc(0, 0, 0, 0, 1, 15, 0, W'(i % 16), (i % 16 == 0), 0, 1, "l15_run");
        cyc(0, 0, 1, 0, 1, 15, 0, 0, 0, 0, 0, "l15_stop");

        // irq: set with one-shot done, clear racing tc, clear alone
        cyc(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, "irq_clr_idle");
        cyc(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, "irq_os_start");
        cyc(0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1, "irq_os_run");
        cyc(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 1, "irq_os_run");
        cyc(0, 0, 0, 0, 0, 2, 0, 2, 1, 1, 0, "irq_os_done");
        cyc(0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, "irq_hold");
        cyc(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, "irq_p1_start");
        cyc(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, "irq_p1_run");
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, "irq_clr_vs_tc_set");
        cyc(0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, "irq_clr_vs_tc_vis");
        cyc(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, "irq_p1_stop");
        cyc(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, "irq_clr_alone");

        // Reset in the middle of a run
        cyc(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 1, "mr_start");
        cyc(0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 1, "mr_run");
        cyc(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, "reset_midrun");
        cyc(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, "after_reset");

        // Drain the scoreboard with a bounded wait
        @(posedge clk);
        #2;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_count_ctrl

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
- Run-control sequencer for the team's free-running up-counter datapath.
- Adds start/stop/pause, a programmable terminal value, one-shot or periodic mode, and terminal-count and done pulses.
- Sits between a host/control FSM and the counter. Software-style control is reduced to single-cycle command pulses.

Parameters:
- WIDTH, 4, counter and limit width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- start  input  1  command pulse; begin a count run. Honoured only in IDLE.
- stop  input  1  command pulse; abort the run and return to IDLE.
- pause  input  1  level; freezes the count while high.
- periodic  input  1  mode select, sampled at start: 1 = auto-reload, 0 = one-shot.
- limit  input  WIDTH  terminal value, sampled at start.
- count  output  WIDTH  current count value.
- busy  output  1  high in RUN or PAUSE.
- tc  output  1  one-cycle terminal-count pulse.
- done  output  1  one-cycle pulse when a one-shot run completes.
- state  output  2  FSM state encoding.
- irq  output  1  sticky interrupt flag; see Optional Feature.
- irq_clr  input  1  clears irq.

Behaviour:
- All outputs are registered; no combinational input-to-output paths.
- Reset: state=IDLE; count=0, busy=0, tc=0, done=0, irq=0; internal limit_q=0, mode_q=0.
- Command priority: reset > stop > pause > start/count.
- States: IDLE=0, RUN=1, PAUSE=2. Encoding 3 is illegal and recovers to IDLE on the next clock.
- IDLE:
  - start=1 and stop=0 -> latch limit_q<=limit, mode_q<=periodic, count<=0, go to RUN.
  - busy=1 from the next cycle.
  - stop in IDLE is a no-op; start is ignored whenever stop=1.
- RUN, evaluated each cycle:
  - stop=1 -> IDLE, count<=0; no tc, no done.
  - Else pause=1 -> PAUSE; count holds.
  - Else count==limit_q -> tc<=1 (visible the next cycle). Then:
    - Periodic: count<=0, stay in RUN.
    - One-shot: count holds at limit_q, done<=1, go to IDLE.
  - Else count<=count+1, arithmetic modulo 2^WIDTH.
- PAUSE:
  - stop=1 -> IDLE, count<=0.
  - pause=0 -> RUN; counting resumes on the following edge.
  - Otherwise hold all values.
- start outside IDLE is ignored; the run is not restarted and limit/mode are not resampled.
- Changes to limit or periodic mid-run have no effect until the next start.
- limit=0:
  - Periodic -> tc asserted every RUN cycle, count stays 0.
  - One-shot -> completes one cycle after entering RUN.
- limit=2^WIDTH-1: count reaches the all-ones value, then reloads 0 (periodic). No overflow beyond limit_q.
- Period in periodic mode = limit_q+1 un-paused RUN cycles.
- tc and done are single-cycle pulses, self-clearing.
- Reset mid-run: immediate return to IDLE next edge; outputs take their reset values.

Optional Feature:
- Macro COUNT_CTRL_IRQ_EN.
- Defined:
  - irq sets on any tc or done.
  - irq clears on irq_clr.
  - Set wins over clear in the same cycle.
  - irq is cleared by reset.
- Undefined: irq is tied 0; irq_clr is unused. The port list is identical in both builds.

Decomposition:
- Package count_ctrl_pkg holds:
  - The state typedef/constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2.
  - The default WIDTH constant.
- One sub-module, cnt_core: WIDTH-bit register with synchronous clear, enable and hold.
  - count_ctrl drives its clr/en from the FSM.
  - cnt_core contains no control logic.

Test Plan:
- Reset, then periodic=1, limit=3, start pulse -> count sequence 0,1,2,3,0,1…; tc high one cycle after each count==3; busy=1; done never asserts.
- periodic=0, limit=5, start -> count 0..5; tc and done pulse together once; state returns to IDLE with count holding 5 and busy=0.
- Periodic, limit=9: pause high for 4 cycles at count=4 -> count holds 4, state=PAUSE; after release, count continues 5,6…
- stop asserted at count=2 while in PAUSE, with start asserted in the same cycle -> IDLE, count=0, no tc/done, start ignored.
- limit=0 periodic -> tc every cycle. limit=15 periodic -> count 0..15 then 0; tc exactly once per 16 cycles.
- Build with COUNT_CTRL_IRQ_EN, limit=2 one-shot -> irq sets with done. irq_clr coincident with a new tc keeps irq=1; a later irq_clr alone clears it.
